// File: rtl/cat_cmd_decoder.sv
// cat_cmd_decoder: byte-level cat command parser feeding the badge LEDs.
// Single-byte commands set or clear one cat, light all cats, or start a
// three-byte "#hh" command that loads the whole status byte.
// Optional feature macro: CAT_CMD_ACK_EN adds the acknowledge channel and its
// ACK state. When it is undefined, every command returns straight to IDLE and
// the decoder accepts one byte per cycle.
module cat_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 10_334_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] ack_data,
  output logic       ack_valid,
  input  logic       ack_ready,
  output logic [7:0] cat_status,
  output logic       cmd_err
);

  // The counter only has to hold values up to TIMEOUT_CYCLES-1: the
  // timeout fires on the cycle it would have reached TIMEOUT_CYCLES.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ACK_OK  = 8'h2B;
  localparam logic [7:0] ACK_NAK = 8'h2D;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEX_HI = 2'd1,
    S_HEX_LO = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       hi_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       cat_q;
  logic             err_q;
`ifdef CAT_CMD_ACK_EN
  logic             ack_valid_q;
  logic [7:0]       ack_data_q;
`endif

  // Per-cycle decode of the presented byte against the current state.
  logic       accept_d;
  logic       is_hex_d;
  logic [3:0] nib_d;
  logic [2:0] idx_d;
  logic [7:0] cat_d;
  logic       term_d;
  logic       ok_d;
  logic       to_hex_d;
  logic       latch_hi_d;
  logic       timeout_d;

`ifdef CAT_CMD_ACK_EN
  assign rx_ready = (state_q != S_ACK);
`else
  assign rx_ready = 1'b1;
`endif

  // Decode the byte: what it does to the cat bits and whether it ends a command.
  always_comb begin
    accept_d   = rx_valid && rx_ready;
    is_hex_d   = ((rx_data >= 8'h30) && (rx_data <= 8'h39)) ||
                 ((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
                 ((rx_data >= 8'h61) && (rx_data <= 8'h66));
    // Letters A-F / a-f both have bit 6 set; digits do not.
    nib_d      = rx_data[6] ? (rx_data[3:0] + 4'd9) : rx_data[3:0];
    // 'A'/'a' have low bits 001 and 'H'/'h' have 000, so subtracting one
    // maps them onto cat indices 0..7.
    idx_d      = rx_data[2:0] - 3'd1;
    cat_d      = cat_q;
    term_d     = 1'b0;
    ok_d       = 1'b0;
    to_hex_d   = 1'b0;
    latch_hi_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_d) begin
          if ((rx_data >= 8'h41) && (rx_data <= 8'h48)) begin
            cat_d[idx_d] = 1'b0;
            term_d       = 1'b1;
            ok_d         = 1'b1;
          end else if ((rx_data >= 8'h61) && (rx_data <= 8'h68)) begin
            cat_d[idx_d] = 1'b1;
            term_d       = 1'b1;
            ok_d         = 1'b1;
          end else if (rx_data == 8'h60) begin
            cat_d  = 8'hFF;
            term_d = 1'b1;
            ok_d   = 1'b1;
          end else if (rx_data == 8'h23) begin
            to_hex_d = 1'b1;
          end else if ((rx_data == 8'h0A) || (rx_data == 8'h0D)) begin
            term_d = 1'b0;
          end else begin
            term_d = 1'b1;
          end
        end
      end
      S_HEX_HI: begin
        if (accept_d) begin
          if (is_hex_d) latch_hi_d = 1'b1;
          else          term_d     = 1'b1;
        end else begin
          timeout_d = (cnt_q == CNT_LAST);
        end
      end
      S_HEX_LO: begin
        if (accept_d) begin
          term_d = 1'b1;
          if (is_hex_d) begin
            cat_d = {hi_q, nib_d};
            ok_d  = 1'b1;
          end
        end else begin
          timeout_d = (cnt_q == CNT_LAST);
        end
      end
      default: begin
        term_d = 1'b0;
      end
    endcase
  end

  // Command FSM with registered status, error pulse and acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hi_q        <= 4'h0;
      cnt_q       <= '0;
      cat_q       <= 8'hFF;
      err_q       <= 1'b0;
`ifdef CAT_CMD_ACK_EN
      ack_valid_q <= 1'b0;
      ack_data_q  <= 8'h00;
`endif
    end else begin
      cat_q <= cat_d;
      err_q <= (term_d && !ok_d) || timeout_d;

      if (accept_d)
        cnt_q <= '0;
      else if ((state_q == S_HEX_HI) || (state_q == S_HEX_LO))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (to_hex_d) state_q <= S_HEX_HI;
        end
        S_HEX_HI: begin
          if (latch_hi_d) begin
            hi_q    <= nib_d;
            state_q <= S_HEX_LO;
          end else if (timeout_d) begin
            state_q <= S_IDLE;
          end
        end
        S_HEX_LO: begin
          if (timeout_d) state_q <= S_IDLE;
        end
`ifdef CAT_CMD_ACK_EN
        S_ACK: begin
          if (ack_ready) begin
            ack_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // A terminating byte overrides the per-state transition above.
      if (term_d) begin
`ifdef CAT_CMD_ACK_EN
        state_q     <= S_ACK;
        ack_valid_q <= 1'b1;
        ack_data_q  <= ok_d ? ACK_OK : ACK_NAK;
`else
        state_q     <= S_IDLE;
`endif
      end
    end
  end

  assign cat_status = cat_q;
  assign cmd_err    = err_q;

`ifdef CAT_CMD_ACK_EN
  assign ack_valid = ack_valid_q;
  assign ack_data  = ack_data_q;
`else
  logic unused_ack_ready;
  assign unused_ack_ready = ack_ready;
  assign ack_valid = 1'b0;
  assign ack_data  = 8'h00;
`endif

endmodule

// File: tb/tb_cat_cmd_decoder.sv
// Bench for cat_cmd_decoder: vector table, hand-written corner sequences and
// a randomized run checked against a command-level reference model.
module tb_cat_cmd_decoder;

  localparam int TO = 16;
`ifdef CAT_CMD_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] ack_data;
  logic       ack_valid;
  logic       ack_ready;
  logic [7:0] cat_status;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  cat_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ack_data(ack_data), .ack_valid(ack_valid), .ack_ready(ack_ready),
    .cat_status(cat_status), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte until it is accepted (bounded), leaving time at #1 after
  // the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  // Complete a pending acknowledge and check it was the expected byte.
  task automatic finish_ack(input logic [7:0] exp);
`ifdef CAT_CMD_ACK_EN
    check("ack_valid_pending", 32'(ack_valid), 32'd1);
    check("ack_data_pending", 32'(ack_data), 32'(exp));
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    check("ack_cleared", 32'(ack_valid), 32'd0);
    check("rx_ready_after_ack", 32'(rx_ready), 32'd1);
`else
    check("ack_valid_tied", 32'(ack_valid), 32'd0);
    check("ack_data_tied", 32'(ack_data), 32'(exp & 8'h00));
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_status"}, 32'(cat_status), 32'hFF);
    check({tag, "_ack_valid"}, 32'(ack_valid), 32'd0);
    check({tag, "_ack_data"}, 32'(ack_data), 32'd0);
    check({tag, "_cmd_err"}, 32'(cmd_err), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  // ---------------- reference model (command level) ----------------
  logic [7:0] m_stat;
  logic       m_err;
  logic       m_pend;
  logic [7:0] m_ackd;
  logic       m_ackd_known;
  logic [7:0] m_cmd[$];   // bytes of an unfinished '#' command
  int         m_idle;

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic m_finish(input bit ok);
    if (!ok) m_err = 1'b1;
    if (ACK_EN) begin
      m_pend       = 1'b1;
      m_ackd       = ok ? 8'h2B : 8'h2D;
      m_ackd_known = 1'b1;
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit ar);
    int h;
    if (r) begin
      m_stat = 8'hFF; m_err = 1'b0; m_pend = 1'b0; m_ackd = 8'h00;
      m_ackd_known = 1'b1; m_cmd.delete(); m_idle = 0;
      return;
    end
    m_err = 1'b0;
    if (ACK_EN && m_pend) begin
      if (ar) m_pend = 1'b0;
    end else if (v) begin
      m_idle = 0;
      if (m_cmd.size() > 0) begin
        h = hexval(d);
        if (h < 0) begin
          m_cmd.delete();
          m_finish(1'b0);
        end else if (m_cmd.size() == 1) begin
          m_cmd.push_back(d);
        end else begin
          m_stat = 8'(hexval(m_cmd[1]) * 16 + h);
          m_cmd.delete();
          m_finish(1'b1);
        end
      end else if (d >= "A" && d <= "H") begin
        m_stat = m_stat & ~(8'h01 << (int'(d) - 65));
        m_finish(1'b1);
      end else if (d >= "a" && d <= "h") begin
        m_stat = m_stat | (8'h01 << (int'(d) - 97));
        m_finish(1'b1);
      end else if (d == 8'h60) begin
        m_stat = 8'hFF;
        m_finish(1'b1);
      end else if (d == "#") begin
        m_cmd.push_back(d);
      end else if (d == 8'h0A || d == 8'h0D) begin
        m_idle = 0;
      end else begin
        m_finish(1'b0);
      end
    end else if (m_cmd.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1'b1;
        m_cmd.delete();
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    string hexs;
    hexs = "0123456789abcdefABCDEF";
    case ($urandom_range(0, 5))
      0: return 8'(65 + $urandom_range(0, 7));
      1: return 8'(97 + $urandom_range(0, 7));
      2: return 8'h23;
      3: return 8'(hexs[$urandom_range(0, 21)]);
      4: return ($urandom_range(0, 1) != 0) ? 8'h60 : 8'h0D;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] status;
    logic       err;
    logic [7:0] ack;    // 0 = no acknowledge expected
  } vec_t;

  vec_t tbl[24];

  initial begin
    tbl[0]  = '{8'h43, 8'hFB, 1'b0, 8'h2B};  // 'C'
    tbl[1]  = '{8'h23, 8'hFB, 1'b0, 8'h00};  // '#'
    tbl[2]  = '{8'h35, 8'hFB, 1'b0, 8'h00};  // '5'
    tbl[3]  = '{8'h61, 8'h5A, 1'b0, 8'h2B};  // 'a' -> 5A
    tbl[4]  = '{8'h60, 8'hFF, 1'b0, 8'h2B};  // '`'
    tbl[5]  = '{8'h5A, 8'hFF, 1'b1, 8'h2D};  // 'Z'
    tbl[6]  = '{8'h23, 8'hFF, 1'b0, 8'h00};
    tbl[7]  = '{8'h34, 8'hFF, 1'b0, 8'h00};
    tbl[8]  = '{8'h67, 8'hFF, 1'b1, 8'h2D};  // 'g' not hex
    tbl[9]  = '{8'h0D, 8'hFF, 1'b0, 8'h00};
    tbl[10] = '{8'h41, 8'hFE, 1'b0, 8'h2B};
    tbl[11] = '{8'h42, 8'hFC, 1'b0, 8'h2B};
    tbl[12] = '{8'h62, 8'hFE, 1'b0, 8'h2B};
    tbl[13] = '{8'h23, 8'hFE, 1'b0, 8'h00};
    tbl[14] = '{8'h30, 8'hFE, 1'b0, 8'h00};
    tbl[15] = '{8'h30, 8'h00, 1'b0, 8'h2B};  // "#00"
    tbl[16] = '{8'h68, 8'h80, 1'b0, 8'h2B};  // 'h'
    tbl[17] = '{8'h23, 8'h80, 1'b0, 8'h00};
    tbl[18] = '{8'h47, 8'h80, 1'b1, 8'h2D};  // 'G' not hex
    tbl[19] = '{8'h23, 8'h80, 1'b0, 8'h00};
    tbl[20] = '{8'h66, 8'h80, 1'b0, 8'h00};  // 'f'
    tbl[21] = '{8'h43, 8'hFC, 1'b0, 8'h2B};  // 'C' as low nibble
    tbl[22] = '{8'h0A, 8'hFC, 1'b0, 8'h00};
    tbl[23] = '{8'h48, 8'h7C, 1'b0, 8'h2B};  // 'H'

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("reset");

    for (int i = 0; i < 24; i++) begin
      send(tbl[i].data);
      check($sformatf("vec%0d_status", i), 32'(cat_status), 32'(tbl[i].status));
      check($sformatf("vec%0d_err", i), 32'(cmd_err), 32'(tbl[i].err));
      if (tbl[i].ack != 8'h00) finish_ack(tbl[i].ack);
      else check($sformatf("vec%0d_no_ack", i), 32'(ack_valid), 32'd0);
    end

    // Timeout: '#' then 16 idle cycles, exactly one error pulse.
    send(8'h23);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) check($sformatf("timeout_early_%0d", k), 32'(cmd_err), 32'd0);
      else        check("timeout_err", 32'(cmd_err), 32'd1);
    end
    check("timeout_no_ack", 32'(ack_valid), 32'd0);
    tick();
    check("timeout_err_one_cycle", 32'(cmd_err), 32'd0);
    send(8'h62);
    check("after_timeout_b", 32'(cat_status), 32'h7E);
    finish_ack(8'h2B);

    // A byte landing on the timeout cycle wins.
    send(8'h23);
    for (int k = 1; k < TO; k++) tick();
    send(8'h37);
    check("boundary_byte_wins_err", 32'(cmd_err), 32'd0);
    send(8'h37);
    check("boundary_status", 32'(cat_status), 32'h77);
    check("boundary_err", 32'(cmd_err), 32'd0);
    finish_ack(8'h2B);

    // Backpressure / throughput.
    send(8'h60);
    finish_ack(8'h2B);
`ifdef CAT_CMD_ACK_EN
    send(8'h41);
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("stall_rx_ready_%0d", k), 32'(rx_ready), 32'd0);
      tick();
    end
    check("stall_status", 32'(cat_status), 32'hFE);
    check("stall_ack_data", 32'(ack_data), 32'h2B);
    ack_ready = 1'b1;
    tick();
    ack_ready = 1'b0;
    check("stall_release_ready", 32'(rx_ready), 32'd1);
    check("stall_B_not_taken", 32'(cat_status), 32'hFE);
    tick();
    rx_valid = 1'b0;
    check("stall_B_taken", 32'(cat_status), 32'hFC);
    finish_ack(8'h2B);
`else
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    tick();
    check("stream_ready_1", 32'(rx_ready), 32'd1);
    rx_data  = 8'h42;
    tick();
    rx_valid = 1'b0;
    check("stream_status", 32'(cat_status), 32'hFC);
`endif

    // Reset in HEX_LO, then reset during a pending ack.
    send(8'h23);
    send(8'h33);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("rst_hexlo");
    send(8'h44);
    check("pre_rst_status", 32'(cat_status), 32'hF7);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_vals("rst_ack");
    send(8'h0D);
    check("cr_err", 32'(cmd_err), 32'd0);
    check("cr_ack", 32'(ack_valid), 32'd0);
    check("cr_status", 32'(cat_status), 32'hFF);

    // Randomized run against the reference model.
    begin
      bit r, v, ar;
      logic [7:0] d;
      int pct;
      logic mdl_rdy;
      model_step(1'b1, 1'b0, 8'h00, 1'b0);
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        case ((i / 300) % 3)
          0: pct = 90;
          1: pct = 40;
          default: pct = 5;
        endcase
        r  = ($urandom_range(0, 299) == 0);
        v  = ($urandom_range(0, 99) < pct);
        d  = rand_byte();
        ar = ($urandom_range(0, 3) != 0);
        if (m_pend || m_cmd.size() > 0 || r) m_ackd_known = m_ackd_known;
        model_step(r, v, d, ar);
        reset = r; rx_valid = v; rx_data = d; ack_ready = ar;
        tick();
        mdl_rdy = ACK_EN ? !m_pend : 1'b1;
        check($sformatf("rand%0d_outputs", i),
              {20'd0, rx_ready, cmd_err, ack_valid, 1'b0, cat_status},
              {20'd0, mdl_rdy, m_err, m_pend, 1'b0, m_stat});
        if (m_pend || (m_ackd_known && m_ackd == 8'h00))
          check($sformatf("rand%0d_ack_data", i), 32'(ack_data), 32'(m_ackd));
        if (!m_pend && m_ackd != 8'h00) m_ackd_known = 1'b0;
        if (r) m_ackd_known = 1'b1;
      end
      reset = 1'b0; rx_valid = 1'b0; ack_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
